// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the CPU data bus.
// CPU stores to TXDATA push bytes into a TX FIFO. A baud-timed FSM sends
// each byte as one start bit (0), eight data bits LSB first and one stop
// bit (1). CPU loads return status and configuration without side effects.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   re / we      bus read / write enable
//   addr_bus     byte address; bits [3:2] select the register inside the window
//   data_bus_in  write data
//   data_bus_out read data, zero unless this window is read (OR-mux friendly)
//   tx           registered serial line, idles high
//   irq          irq_en && FIFO empty && FSM idle
//
// Register map (offset from BASE_ADDR):
//   0x0 TXDATA   W  push [7:0]; reads 0
//   0x4 STATUS   RO [0] busy, [1] full, [2] empty, [3] overflow, [12:8] count
//   0x8 CTRL     RW [0] enable, [1] irq_en, [2] clr_ovf (write-only strobe)
//   0xC BAUD_DIV RW [15:0] clocks per bit, 0 behaves as 1
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr_bus,
  input  logic [31:0] data_bus_in,
  output logic [31:0] data_bus_out,
  output logic        tx,
  output logic        irq
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Configuration and sticky status
  logic        enable_r;
  logic        irq_en_r;
  logic        overflow_r;
  logic [15:0] baud_div_r;

  // FIFO storage
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [4:0]    count_r;

  // Transmit engine
  state_t      state_r, state_nx;
  logic [15:0] baud_cnt_r, baud_cnt_nx;
  logic [2:0]  bit_cnt_r, bit_cnt_nx;
  logic [7:0]  shift_r, shift_nx;
  logic        tx_r, tx_nx;
  logic        pop_s;

  // Bus decode
  logic        hit_s;
  logic [1:0]  sel_s;
  logic        wr_hit_s;
  logic        push_req_s;
  logic        push_ok_s;
  logic        ovf_set_s;
  logic        clr_ovf_s;
  logic        full_s;
  logic        empty_s;
  logic        busy_s;
  logic [15:0] div_eff_s;
  logic        unused_bits_s;

  assign hit_s      = (addr_bus[31:4] == BASE_ADDR[31:4]);
  assign sel_s      = addr_bus[3:2];
  assign wr_hit_s   = we && hit_s;
  assign full_s     = (count_r == DEPTH_C);
  assign empty_s    = (count_r == 5'd0);
  assign busy_s     = (state_r != ST_IDLE);
  // A push into a full FIFO still fits if the FSM frees a slot on the same edge.
  assign push_req_s = wr_hit_s && (sel_s == 2'd0);
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign ovf_set_s  = push_req_s && !push_ok_s;
  assign clr_ovf_s  = wr_hit_s && (sel_s == 2'd2) && data_bus_in[2];
  assign div_eff_s  = (baud_div_r == 16'd0) ? 16'd1 : baud_div_r;

  assign unused_bits_s = ^{addr_bus[1:0], data_bus_in[31:16]};

  assign tx  = tx_r;
  assign irq = irq_en_r && empty_s && (state_r == ST_IDLE);

  // Combinational read mux; zero outside the window so it can be OR-ed with memory
  always_comb begin
    data_bus_out = 32'd0;
    if (re && hit_s) begin
      case (sel_s)
        2'd0:    data_bus_out = 32'd0;
        2'd1:    data_bus_out = {19'd0, count_r, 4'd0, overflow_r, empty_s, full_s, busy_s};
        2'd2:    data_bus_out = {30'd0, irq_en_r, enable_r};
        2'd3:    data_bus_out = {16'd0, baud_div_r};
        default: data_bus_out = 32'd0;
      endcase
    end else begin
      data_bus_out = 32'd0;
    end
  end

  // CTRL, BAUD_DIV and sticky overflow (a coinciding overflow beats clr_ovf)
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r   <= 1'b1;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
      baud_div_r <= DEFAULT_DIV;
    end else begin
      if (wr_hit_s && (sel_s == 2'd2)) begin
        enable_r <= data_bus_in[0];
        irq_en_r <= data_bus_in[1];
      end
      if (wr_hit_s && (sel_s == 2'd3)) begin
        baud_div_r <= data_bus_in[15:0];
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FIFO data array (no reset needed, validity is tracked by count_r)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= data_bus_in[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 5'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmit FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_nx;
      baud_cnt_r <= baud_cnt_nx;
      bit_cnt_r  <= bit_cnt_nx;
      shift_r    <= shift_nx;
      tx_r       <= tx_nx;
    end
  end

  // Transmit FSM next state; tx_nx is the line level belonging to the next
  // state, so the registered tx changes on the same edge as the state.
  always_comb begin
    state_nx    = state_r;
    baud_cnt_nx = baud_cnt_r;
    bit_cnt_nx  = bit_cnt_r;
    shift_nx    = shift_r;
    tx_nx       = tx_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_nx = 1'b1;
        if (enable_r && !empty_s) begin
          pop_s       = 1'b1;
          shift_nx    = fifo_mem_r[rd_ptr_r];
          baud_cnt_nx = div_eff_s - 16'd1;
          bit_cnt_nx  = 3'd0;
          state_nx    = ST_START;
          tx_nx       = 1'b0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_cnt_r == 16'd0) begin
          baud_cnt_nx = div_eff_s - 16'd1;
          state_nx    = ST_DATA;
          tx_nx       = shift_r[0];
        end else begin
          baud_cnt_nx = baud_cnt_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_cnt_r == 16'd0) begin
          baud_cnt_nx = div_eff_s - 16'd1;
          if (bit_cnt_r == 3'd7) begin
            state_nx = ST_STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt_r + 3'd1;
            shift_nx   = {1'b0, shift_r[7:1]};
            tx_nx      = shift_r[1];
          end
        end else begin
          baud_cnt_nx = baud_cnt_r - 16'd1;
        end
      end
      ST_STOP: begin
        tx_nx = 1'b1;
        if (baud_cnt_r == 16'd0) begin
          state_nx = ST_IDLE;
        end else begin
          baud_cnt_nx = baud_cnt_r - 16'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter. It is the responder on the CPU data-memory bus (re/we/addr_bus/data_bus_in/data_bus_out), sitting beside the data memory. CPU stores push bytes into a TX FIFO, and a baud-timed FSM serialises them 8N1, LSB first, on a single line. CPU loads read the status and configuration registers.

Parameters:
- BASE_ADDR, 32'h0000_1000: 16-byte register window base; bits [3:0] are ignored.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of 2, range 2..16.
- DEFAULT_DIV, 16'd868: reset value of BAUD_DIV, in clock cycles per bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- re  in  1  bus read enable
- we  in  1  bus write enable
- addr_bus  in  32  byte address
- data_bus_in  in  32  write data
- data_bus_out  out  32  read data; 0 when not selected
- tx  out  1  serial output; idles high
- irq  out  1  high when CTRL.irq_en=1 and FIFO empty and FSM in IDLE

Behaviour:
Decode and bus timing
- hit = (addr_bus[31:4] == BASE_ADDR[31:4]). addr_bus[1:0] is ignored; the register is selected by addr_bus[3:2].
- Reads are zero-wait and combinational from register state. data_bus_out = 0 unless re && hit, so it can be OR-muxed with the data memory.
- Reads have no side effects.
- Writes take effect at the posedge where we && hit.
- re and we in the same cycle are both serviced; the read returns the pre-write value.

Register map
- 0x0 TXDATA, W: push data_bus_in[7:0]. Reads return 0.
- 0x4 STATUS, RO:
  - [0] busy (FSM != IDLE)
  - [1] full
  - [2] empty
  - [3] overflow (sticky)
  - [12:8] fifo count
  - all other bits 0
- 0x8 CTRL, R/W:
  - [0] enable, reset 1
  - [1] irq_en, reset 0
  - [2] clr_ovf: write 1 clears overflow; always reads 0
- 0xC BAUD_DIV, R/W [15:0], reset DEFAULT_DIV. A value of 0 is treated as 1. Upper bits read 0.

FIFO
- Push is accepted when count < FIFO_DEPTH, or when a pop happens in the same cycle.
- A push to a full FIFO with no simultaneous pop is dropped and sets overflow.
- If a clr_ovf write coincides with an overflowing push, set wins.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

TX FSM (IDLE, START, DATA, STOP)
- IDLE: tx=1. If enable && !empty: pop the head into the shift register, load baud_cnt = div-1, go to START. The pop happens on this transition edge.
- START: tx=0 for div cycles.
- DATA: tx = shift[0] for div cycles per bit; shift right; bit counter 0..7. Go to STOP after bit 7.
- STOP: tx=1 for div cycles, then go to IDLE.
- IDLE re-checks the FIFO on the next cycle, so the inter-frame gap is exactly 1 clock.
- Frame length = 10*div clocks, plus 1 idle cycle between back-to-back frames.
- baud_cnt reload always uses the current BAUD_DIV. A mid-frame BAUD_DIV write takes effect at the next bit boundary.
- Clearing enable mid-frame lets the current frame finish; the FSM then holds in IDLE with FIFO contents retained.
- tx is registered (no glitches).

Reset
- Applies on any cycle, including mid-frame.
- Next cycle after reset: tx=1, state IDLE, FIFO empty, count 0, overflow 0, CTRL=0x1, BAUD_DIV=DEFAULT_DIV, irq=0.
- data_bus_out remains purely combinational (0 unless re && hit).

Test Plan:
- Reset: DEFAULT_DIV=4. After reset, read 0x1004 -> 0x0000_0004 (empty). Read 0x1008 -> 0x1. Read 0x100C -> 4. tx=1.
- Single byte: write 0xA5 to 0x1000 -> tx goes low 1 cycle after the write edge. Bits read 1,0,1,0,0,1,0,1, each 4 clocks, then 4 clocks high. STATUS.busy=1 throughout the frame, 0 afterwards.
- Back-to-back: write 0x00, 0xFF, 0x55 in consecutive cycles -> three frames of 40 clocks each, separated by exactly 1 idle clock. count peaks at 2 while the first byte is shifting.
- Overflow: enable=0; write 9 bytes -> STATUS count=8, full=1, overflow=1, 9th byte absent. Write CTRL=0x5 -> overflow=0; frames resume draining 8 bytes.
- Decode and simultaneous access: read 0x2004 -> data_bus_out=0. Write BAUD_DIV=2 mid-bit -> bit lengths change at the next boundary. Assert re+we on 0x100C in the same cycle -> the read returns the old divisor.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 the next cycle, STATUS=0x4, no residual frame after reset deasserts.
